// File: rtl/fetch_stage_ctrl_if.sv
// Instruction-memory fetch bus: request/address out, valid/data back.
interface fetch_stage_ctrl_if;
  logic        req;
  logic [15:0] addr;
  logic        valid;
  logic [15:0] data;

  modport master (output req, addr, input valid, data);
  modport slave  (input req, addr, output valid, data);
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC and IF/ID register, handles stall, branch squash and HLT.
module fetch_stage_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000,
  parameter logic [3:0]  HLT_OP   = 4'b1111
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       if_flush,
  input  logic [15:0]                br_target,
  fetch_stage_ctrl_if.master         imem,
  output logic [15:0]                if_id_inst,
  output logic [15:0]                if_id_pc_plus2,
  output logic                       if_id_valid,
  output logic [15:0]                pc_out,
  output logic                       halted
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD, HALT} state_t;

  state_t      state;
  logic [15:0] pcReg;
  logic [15:0] bufInst;
  logic [15:0] redirPc;
  logic [15:0] pcPlus2;

  assign pcPlus2   = pcReg + 16'd2;
  assign imem.req  = (state == FETCH) || (state == DRAIN);
  assign imem.addr = pcReg;
  assign pc_out    = pcReg;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      pcReg          <= RESET_PC;
      bufInst        <= '0;
      redirPc        <= '0;
      if_id_inst     <= NOP_INST;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (if_flush) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            if (imem.valid) begin
              pcReg <= br_target;
            end else begin
              redirPc <= br_target;
              state   <= DRAIN;
            end
          end else if (stall) begin
            // Data arriving while ID is stalled is parked; the bus request drops until it is consumed.
            if (imem.valid) begin
              bufInst <= imem.data;
              state   <= HOLD;
            end
          end else if (imem.valid) begin
            if_id_inst     <= imem.data;
            if_id_pc_plus2 <= pcPlus2;
            if_id_valid    <= 1'b1;
            if (imem.data[15:12] == HLT_OP) state <= HALT;
            else                            pcReg <= pcPlus2;
          end else begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
          end
        end

        DRAIN: begin
          // Keep the squashed request's address on the bus until memory answers it.
          if_id_inst  <= NOP_INST;
          if_id_valid <= 1'b0;
          if (imem.valid) begin
            pcReg <= if_flush ? br_target : redirPc;
            state <= FETCH;
          end else if (if_flush) begin
            redirPc <= br_target;
          end
        end

        HOLD: begin
          if (if_flush) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            pcReg       <= br_target;
            state       <= FETCH;
          end else if (!stall) begin
            if_id_inst     <= bufInst;
            if_id_pc_plus2 <= pcPlus2;
            if_id_valid    <= 1'b1;
            if (bufInst[15:12] == HLT_OP) begin
              state <= HALT;
            end else begin
              pcReg <= pcPlus2;
              state <= FETCH;
            end
          end
        end

        HALT: begin
          if (if_flush) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            pcReg       <= br_target;
            state       <= FETCH;
          end else if (!stall) begin
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
